// File: rtl/rom_pkg.sv
// Shared helpers for the multi-channel ROM: tag-width calculation and channel limits.
package rom_pkg;

  localparam int MAX_CHANNELS = 8;

  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rom_multi_port_array.sv
// Single-read-port synchronous word array with registered output and no reset.
module rom_array #(
  parameter int    WIDTH     = 8,
  parameter int    DEPTH     = 256,
  parameter string INIT_FILE = "",
  localparam int   AW        = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_data_d;
  logic [WIDTH-1:0] rd_data_q;

  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) rd_data_d = mem[rd_addr];
  end

  always_ff @(posedge clock) begin
    rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/rom_multi_port.sv
// Round-robin shared ROM: valid/ready request arbitration with a tagged, pipelined response.
module rom_multi_port
  import rom_pkg::*;
#(
  parameter int    WIDTH     = 8,
  parameter int    DEPTH     = 256,
  parameter int    CHANNELS  = 2,
  parameter int    OUT_REG   = 0,
  parameter string INIT_FILE = "",
  localparam int   AW        = $clog2(DEPTH),
  localparam int   CW        = clog2_min1(CHANNELS)
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [CHANNELS-1:0] req_valid,
  input  logic [AW-1:0]       req_addr [CHANNELS],
  output logic [CHANNELS-1:0] req_ready,
  output logic [CHANNELS-1:0] rsp_valid,
  output logic [WIDTH-1:0]    rsp_data,
  output logic [CW-1:0]       rsp_chan
);

  typedef struct packed {
    logic [CHANNELS-1:0] valid;
    logic [CW-1:0]       chan;
    logic [WIDTH-1:0]    data;
  } rom_rsp_t;

  logic [CW-1:0]       rr_d, rr_q;
  logic [CW-1:0]       cand;
  logic [CW-1:0]       grant_idx;
  logic                grant_found;
  logic [AW-1:0]       sel_addr;
  logic                in_range;
  logic                rd_en;
  logic [WIDTH-1:0]    array_data;

  logic [CHANNELS-1:0] s1_valid_d, s1_valid_q;
  logic [CW-1:0]       s1_chan_d, s1_chan_q;
  logic                s1_zero_d, s1_zero_q;
  logic                s1_filled_d, s1_filled_q;
  rom_rsp_t            s1;
  rom_rsp_t            rsp;

  // Search from rr upward with wraparound; the first requester found wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    req_ready   = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      cand = CW'((int'(rr_q) + k) % CHANNELS);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
    if (grant_found) req_ready[grant_idx] = 1'b1;
  end

  assign sel_addr = req_addr[grant_idx];
  assign in_range = {1'b0, sel_addr} < (AW + 1)'(DEPTH);
  assign rd_en    = grant_found && in_range;

  rom_array #(
    .WIDTH     (WIDTH),
    .DEPTH     (DEPTH),
    .INIT_FILE (INIT_FILE)
  ) u_array (
    .clock   (clock),
    .rd_en   (rd_en),
    .rd_addr (sel_addr),
    .rd_data (array_data)
  );

  // Tag, zero-mask and channel only move on an accept, so idle cycles hold the last response.
  always_comb begin
    s1_valid_d  = '0;
    s1_chan_d   = s1_chan_q;
    s1_zero_d   = s1_zero_q;
    s1_filled_d = s1_filled_q | grant_found;
    rr_d        = rr_q;
    if (grant_found) begin
      s1_valid_d[grant_idx] = 1'b1;
      s1_chan_d             = grant_idx;
      s1_zero_d             = !in_range;
      rr_d                  = CW'((int'(grant_idx) + 1) % CHANNELS);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rr_q        <= '0;
      s1_valid_q  <= '0;
      s1_chan_q   <= '0;
      s1_zero_q   <= 1'b0;
      s1_filled_q <= 1'b0;
    end else begin
      rr_q        <= rr_d;
      s1_valid_q  <= s1_valid_d;
      s1_chan_q   <= s1_chan_d;
      s1_zero_q   <= s1_zero_d;
      s1_filled_q <= s1_filled_d;
    end
  end

  // The array has no reset, so its data is masked until a read has landed since reset.
  always_comb begin
    s1       = '0;
    s1.valid = s1_valid_q;
    s1.chan  = s1_chan_q;
    s1.data  = (s1_filled_q && !s1_zero_q) ? array_data : '0;
  end

  if (OUT_REG != 0) begin : g_out_reg
    rom_rsp_t s2_d, s2_q;

    always_comb begin
      s2_d = s1;
    end

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) s2_q <= '0;
      else          s2_q <= s2_d;
    end

    assign rsp = s2_q;
  end else begin : g_no_out_reg
    assign rsp = s1;
  end

  assign rsp_valid = rsp.valid;
  assign rsp_data  = rsp.data;
  assign rsp_chan  = rsp.chan;

endmodule

// File: tb/tb_rom_multi_port.sv
// Directed self-checking bench for rom_multi_port across four parameter configurations.
module tb_rom_multi_port;

  logic clock;
  logic reset_n;

  logic [1:0] a_valid, a_ready, a_rsp_valid;
  logic [7:0] a_addr [2];
  logic [7:0] a_rsp_data;
  logic       a_rsp_chan;

  logic [2:0] b_valid, b_ready, b_rsp_valid;
  logic [7:0] b_addr [3];
  logic [7:0] b_rsp_data;
  logic [1:0] b_rsp_chan;

  logic [1:0] c_valid, c_ready, c_rsp_valid;
  logic [7:0] c_addr [2];
  logic [7:0] c_rsp_data;
  logic       c_rsp_chan;

  logic [1:0] d_valid, d_ready, d_rsp_valid;
  logic [7:0] d_addr [2];
  logic [7:0] d_rsp_data;
  logic       d_rsp_chan;

  int test_count;
  int fail_count;

  rom_multi_port #(.WIDTH(8), .DEPTH(256), .CHANNELS(2), .OUT_REG(0)) dut_a (
    .clock(clock), .reset_n(reset_n), .req_valid(a_valid), .req_addr(a_addr),
    .req_ready(a_ready), .rsp_valid(a_rsp_valid), .rsp_data(a_rsp_data), .rsp_chan(a_rsp_chan)
  );

  rom_multi_port #(.WIDTH(8), .DEPTH(256), .CHANNELS(3), .OUT_REG(0)) dut_b (
    .clock(clock), .reset_n(reset_n), .req_valid(b_valid), .req_addr(b_addr),
    .req_ready(b_ready), .rsp_valid(b_rsp_valid), .rsp_data(b_rsp_data), .rsp_chan(b_rsp_chan)
  );

  rom_multi_port #(.WIDTH(8), .DEPTH(256), .CHANNELS(2), .OUT_REG(1)) dut_c (
    .clock(clock), .reset_n(reset_n), .req_valid(c_valid), .req_addr(c_addr),
    .req_ready(c_ready), .rsp_valid(c_rsp_valid), .rsp_data(c_rsp_data), .rsp_chan(c_rsp_chan)
  );

  rom_multi_port #(.WIDTH(8), .DEPTH(200), .CHANNELS(2), .OUT_REG(0)) dut_d (
    .clock(clock), .reset_n(reset_n), .req_valid(d_valid), .req_addr(d_addr),
    .req_ready(d_ready), .rsp_valid(d_rsp_valid), .rsp_data(d_rsp_data), .rsp_chan(d_rsp_chan)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Image mem[i] = i ^ 0xA5 in every instance.
  initial begin
    for (int i = 0; i < 256; i++) begin
      dut_a.u_array.mem[i] = 8'(i) ^ 8'hA5;
      dut_b.u_array.mem[i] = 8'(i) ^ 8'hA5;
      dut_c.u_array.mem[i] = 8'(i) ^ 8'hA5;
    end
    for (int i = 0; i < 200; i++) dut_d.u_array.mem[i] = 8'(i) ^ 8'hA5;
  end

  task automatic test_reset();
    repeat (2) @(posedge clock);
    #1;
    test_count++;
    if ({a_rsp_valid, b_rsp_valid, c_rsp_valid, d_rsp_valid} !== 9'b0) begin
      fail_count++;
      $display("[TB] FAIL reset_valid: got a=%b b=%b c=%b d=%b expected all zero",
               a_rsp_valid, b_rsp_valid, c_rsp_valid, d_rsp_valid);
    end
    test_count++;
    if ({a_rsp_data, b_rsp_data, c_rsp_data, d_rsp_data} !== 32'h0) begin
      fail_count++;
      $display("[TB] FAIL reset_data: got a=%h b=%h c=%h d=%h expected 00",
               a_rsp_data, b_rsp_data, c_rsp_data, d_rsp_data);
    end
    test_count++;
    if ({a_rsp_chan, b_rsp_chan, c_rsp_chan, d_rsp_chan} !== 5'b0) begin
      fail_count++;
      $display("[TB] FAIL reset_chan: got a=%0d b=%0d c=%0d d=%0d expected 0",
               a_rsp_chan, b_rsp_chan, c_rsp_chan, d_rsp_chan);
    end
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_single_read();
    @(negedge clock);
    a_valid   = 2'b01;
    a_addr[0] = 8'h10;
    #1;
    test_count++;
    if (a_ready !== 2'b01) begin
      fail_count++;
      $display("[TB] FAIL single_ready: got %b expected 01", a_ready);
    end
    @(posedge clock);
    #1;
    a_valid = 2'b00;
    test_count++;
    if (a_rsp_valid !== 2'b01 || a_rsp_chan !== 1'b0 || a_rsp_data !== 8'hB5) begin
      fail_count++;
      $display("[TB] FAIL single_rsp: got valid=%b chan=%0d data=%h expected 01/0/b5",
               a_rsp_valid, a_rsp_chan, a_rsp_data);
    end
    @(posedge clock);
    #1;
    test_count++;
    if (a_rsp_valid !== 2'b00 || a_rsp_data !== 8'hB5) begin
      fail_count++;
      $display("[TB] FAIL single_hold: got valid=%b data=%h expected 00/b5",
               a_rsp_valid, a_rsp_data);
    end
  endtask

  task automatic test_round_robin();
    logic [7:0] exp_data [3];
    logic [2:0] exp_oh;
    exp_data = '{8'hA4, 8'hA7, 8'hA6};
    @(negedge clock);
    b_valid   = 3'b111;
    b_addr[0] = 8'h01;
    b_addr[1] = 8'h02;
    b_addr[2] = 8'h03;
    for (int c = 0; c < 6; c++) begin
      if (c != 0) @(negedge clock);
      #1;
      exp_oh = 3'b001 << (c % 3);
      test_count++;
      if (b_ready !== exp_oh) begin
        fail_count++;
        $display("[TB] FAIL rr_ready[%0d]: got %b expected %b", c, b_ready, exp_oh);
      end
      @(posedge clock);
      #1;
      test_count++;
      if (b_rsp_valid !== exp_oh || b_rsp_chan !== 2'(c % 3) || b_rsp_data !== exp_data[c % 3]) begin
        fail_count++;
        $display("[TB] FAIL rr_rsp[%0d]: got valid=%b chan=%0d data=%h expected %b/%0d/%h",
                 c, b_rsp_valid, b_rsp_chan, b_rsp_data, exp_oh, c % 3, exp_data[c % 3]);
      end
    end
    b_valid = 3'b000;
  endtask

  task automatic test_out_reg();
    @(negedge clock);
    c_valid   = 2'b10;
    c_addr[1] = 8'h00;
    #1;
    test_count++;
    if (c_ready !== 2'b10) begin
      fail_count++;
      $display("[TB] FAIL outreg_ready: got %b expected 10", c_ready);
    end
    @(posedge clock);
    #1;
    c_addr[1] = 8'hFF;
    test_count++;
    if (c_rsp_valid !== 2'b00) begin
      fail_count++;
      $display("[TB] FAIL outreg_early: got valid=%b expected 00", c_rsp_valid);
    end
    @(posedge clock);
    #1;
    c_valid = 2'b00;
    test_count++;
    if (c_rsp_valid !== 2'b10 || c_rsp_chan !== 1'b1 || c_rsp_data !== 8'hA5) begin
      fail_count++;
      $display("[TB] FAIL outreg_first: got valid=%b chan=%0d data=%h expected 10/1/a5",
               c_rsp_valid, c_rsp_chan, c_rsp_data);
    end
    @(posedge clock);
    #1;
    test_count++;
    if (c_rsp_valid !== 2'b10 || c_rsp_data !== 8'h5A) begin
      fail_count++;
      $display("[TB] FAIL outreg_second: got valid=%b data=%h expected 10/5a",
               c_rsp_valid, c_rsp_data);
    end
    @(posedge clock);
    #1;
    test_count++;
    if (c_rsp_valid !== 2'b00 || c_rsp_data !== 8'h5A) begin
      fail_count++;
      $display("[TB] FAIL outreg_hold: got valid=%b data=%h expected 00/5a",
               c_rsp_valid, c_rsp_data);
    end
  endtask

  task automatic test_out_of_range();
    @(negedge clock);
    d_valid   = 2'b01;
    d_addr[0] = 8'd199;
    @(posedge clock);
    #1;
    d_addr[0] = 8'd250;
    test_count++;
    if (d_rsp_valid !== 2'b01 || d_rsp_data !== 8'h62) begin
      fail_count++;
      $display("[TB] FAIL oor_last_word: got valid=%b data=%h expected 01/62",
               d_rsp_valid, d_rsp_data);
    end
    @(posedge clock);
    #1;
    d_valid = 2'b00;
    test_count++;
    if (d_rsp_valid !== 2'b01 || d_rsp_data !== 8'h00) begin
      fail_count++;
      $display("[TB] FAIL oor_zero: got valid=%b data=%h expected 01/00",
               d_rsp_valid, d_rsp_data);
    end
  endtask

  task automatic test_reset_during_op();
    @(negedge clock);
    c_valid   = 2'b01;
    c_addr[0] = 8'h20;
    @(posedge clock);
    #1;
    c_valid = 2'b00;
    #2;
    reset_n = 1'b0;
    #1;
    test_count++;
    if (c_rsp_valid !== 2'b00 || c_rsp_data !== 8'h00 || c_rsp_chan !== 1'b0) begin
      fail_count++;
      $display("[TB] FAIL async_reset: got valid=%b data=%h chan=%0d expected 00/00/0",
               c_rsp_valid, c_rsp_data, c_rsp_chan);
    end
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock);
      #1;
      test_count++;
      if (c_rsp_valid !== 2'b00) begin
        fail_count++;
        $display("[TB] FAIL reset_flush[%0d]: got valid=%b expected 00", i, c_rsp_valid);
      end
    end
    @(negedge clock);
    c_valid   = 2'b11;
    c_addr[0] = 8'h20;
    c_addr[1] = 8'h21;
    #1;
    test_count++;
    if (c_ready !== 2'b01) begin
      fail_count++;
      $display("[TB] FAIL reset_rr: got ready=%b expected 01", c_ready);
    end
    @(posedge clock);
    #1;
    c_valid = 2'b00;
    @(posedge clock);
    #1;
    test_count++;
    if (c_rsp_valid !== 2'b01 || c_rsp_data !== 8'h85) begin
      fail_count++;
      $display("[TB] FAIL reset_next_rsp: got valid=%b data=%h expected 01/85",
               c_rsp_valid, c_rsp_data);
    end
  endtask

  task automatic test_withdrawn();
    @(negedge clock);
    a_valid   = 2'b11;
    a_addr[0] = 8'h30;
    a_addr[1] = 8'h31;
    #1;
    test_count++;
    if (a_ready !== 2'b01) begin
      fail_count++;
      $display("[TB] FAIL withdraw_ready: got %b expected 01", a_ready);
    end
    @(posedge clock);
    #1;
    a_valid = 2'b00;
    test_count++;
    if (a_rsp_valid !== 2'b01 || a_rsp_data !== 8'h95) begin
      fail_count++;
      $display("[TB] FAIL withdraw_ch0: got valid=%b data=%h expected 01/95",
               a_rsp_valid, a_rsp_data);
    end
    repeat (2) begin
      @(posedge clock);
      #1;
      test_count++;
      if (a_rsp_valid !== 2'b00) begin
        fail_count++;
        $display("[TB] FAIL withdraw_no_ch1: got valid=%b expected 00", a_rsp_valid);
      end
    end
    @(negedge clock);
    a_valid = 2'b11;
    #1;
    test_count++;
    if (a_ready !== 2'b10) begin
      fail_count++;
      $display("[TB] FAIL withdraw_rr: got ready=%b expected 10", a_ready);
    end
    #1;
    a_valid = 2'b00;
  endtask

  initial begin
    test_count = 0;
    fail_count = 0;
    reset_n    = 1'b0;
    a_valid = '0; b_valid = '0; c_valid = '0; d_valid = '0;
    a_addr  = '{default: '0};
    b_addr  = '{default: '0};
    c_addr  = '{default: '0};
    d_addr  = '{default: '0};

    test_reset();
    test_single_read();
    test_round_robin();
    test_out_reg();
    test_out_of_range();
    test_reset_during_op();
    test_withdrawn();

    repeat (2) @(posedge clock);
    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule
